alu_control_seq: RTL and testbench

Registered, parametrised ALU control unit for the multi-cycle datapath. It decodes the control-unit ALU op (dataUC) and the R-type Function field into an operation code. The extended operation set adds NOR, XOR, SLL, SRL, MULT, DIV, MFHI and MFLO. For MULT/DIV it sequences a fixed-latency busy window with a ready/valid handshake toward the control unit. It sits between the control unit and the ALU / multiply-divide unit, replacing the purely combinational decoder.

---
 rtl/alu_control_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_control_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// Registered ALU control unit: decodes dataUC/Function into an operation code
// and runs a fixed-latency busy window for MULT/DIV with a ready/valid handshake.
module alu_control_seq #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [2:0]      dataUC,
  input  logic [5:0]      Function,
  input  logic            flush,
  output logic            ready_out,
  output logic [OP_W-1:0] operacion,
  output logic            op_valid,
  output logic            illegal,
  output logic            md_start,
  output logic            md_done,
  output logic            busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MULT = OP_W'(9);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MFHI = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MFLO = OP_W'(12);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             ill_q, ill_d;
  logic             opv_q, opv_d;
  logic             mds_q, mds_d;

  logic [OP_W-1:0]  dec_op;
  logic             dec_ill;
  logic             dec_mul;
  logic             dec_div;

  // Request decoder
  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (dataUC)
      3'b000: dec_op = OP_ADD;
      3'b001: dec_op = OP_SUB;
      3'b011: dec_op = OP_AND;
      3'b100: dec_op = OP_OR;
      3'b101: dec_op = OP_XOR;
      3'b111: dec_op = OP_SLT;
      3'b010: begin
        case (Function)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b101010: dec_op = OP_SLT;
          6'b100111: dec_op = OP_NOR;
          6'b100110: dec_op = OP_XOR;
          6'b000000: dec_op = OP_SLL;
          6'b000010: dec_op = OP_SRL;
          6'b011000: begin
            dec_op  = OP_MULT;
            dec_mul = 1'b1;
          end
          6'b011010: begin
            dec_op  = OP_DIV;
            dec_div = 1'b1;
          end
          6'b010000: dec_op = OP_MFHI;
          6'b010010: dec_op = OP_MFLO;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign busy      = (state_q == S_BUSY);
  assign ready_out = (state_q == S_IDLE);
  assign md_done   = busy && (cnt_q == '0);

  assign operacion = op_q;
  assign illegal   = ill_q;
  assign op_valid  = opv_q;
  assign md_start  = mds_q;

  // Flush overrides both the busy countdown and acceptance of a new request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    opv_d   = 1'b0;
    mds_d   = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            op_d  = dec_op;
            ill_d = dec_ill;
            opv_d = 1'b1;
            if (dec_mul || dec_div) begin
              mds_d   = 1'b1;
              state_d = S_BUSY;
              cnt_d   = dec_mul ? MUL_CNT : DIV_CNT;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
      opv_q   <= 1'b0;
      mds_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      opv_q   <= opv_d;
      mds_q   <= mds_d;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: a counting model predicts per-cycle
// handshake outputs and decoded operations; a negedge monitor checks the DUT.
module tb_alu_control_seq;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_in = 1'b0;
  logic [2:0]      dataUC = '0;
  logic [5:0]      Function = '0;
  logic            flush = 1'b0;
  logic            ready_out;
  logic [OP_W-1:0] operacion;
  logic            op_valid;
  logic            illegal;
  logic            md_start;
  logic            md_done;
  logic            busy;

  always #5 clk = ~clk;

  alu_control_seq #(
    .OP_W    (OP_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .dataUC    (dataUC),
    .Function  (Function),
    .flush     (flush),
    .ready_out (ready_out),
    .operacion (operacion),
    .op_valid  (op_valid),
    .illegal   (illegal),
    .md_start  (md_start),
    .md_done   (md_done),
    .busy      (busy)
  );

  typedef struct packed {
    logic busy;
    logic ready;
    logic md_done;
    logic op_valid;
  } cyc_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            ill;
    logic            mds;
  } opx_t;

  cyc_t        cyc_q[$];
  opx_t        op_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          rem      = 0;   // busy cycles left, counting the current one
  bit          mon_en   = 1'b0;

  logic [5:0] fn_list[13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h26,
                              6'h00, 6'h02, 6'h18, 6'h1A, 6'h10, 6'h12};

  function automatic void ref_decode(input logic [2:0] duc, input logic [5:0] fn,
                                     output int op, output bit ill, output int lat);
    op = 0; ill = 1'b0; lat = 0;
    case (duc)
      3'd0: op = 0;
      3'd1: op = 1;
      3'd3: op = 2;
      3'd4: op = 3;
      3'd5: op = 6;
      3'd7: op = 4;
      3'd6: ill = 1'b1;
      default: begin
        case (fn)
          6'h20: op = 0;
          6'h22: op = 1;
          6'h24: op = 2;
          6'h25: op = 3;
          6'h2A: op = 4;
          6'h27: op = 5;
          6'h26: op = 6;
          6'h00: op = 7;
          6'h02: op = 8;
          6'h18: begin op = 9;  lat = MUL_LAT; end
          6'h1A: begin op = 10; lat = DIV_LAT; end
          6'h10: op = 11;
          6'h12: op = 12;
          default: ill = 1'b1;
        endcase
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic seed();
    cyc_q.push_back('{rem > 0, rem == 0, rem == 1, 1'b0});
  endtask

  // Drive one request for the coming edge, predict the cycle after it, advance.
  task automatic step(input bit v, input logic [2:0] duc, input logic [5:0] fn, input bit fl);
    int op; bit ill; int lat; bit acc;
    valid_in = v; dataUC = duc; Function = fn; flush = fl;
    acc = 1'b0;
    if (fl) rem = 0;
    else if (rem > 0) rem--;
    else if (v) begin
      ref_decode(duc, fn, op, ill, lat);
      acc = 1'b1;
      rem = lat;
      op_q.push_back('{OP_W'(op), ill, lat > 0});
    end
    cyc_q.push_back('{rem > 0, rem == 0, rem == 1, acc});
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    cyc_t e;
    opx_t o;
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        check("cyc_expect_present", 32'(cyc_q.size()), 32'd1);
      end else begin
        e = cyc_q.pop_front();
        check("busy", 32'(busy), 32'(e.busy));
        check("ready_out", 32'(ready_out), 32'(e.ready));
        check("md_done", 32'(md_done), 32'(e.md_done));
        check("op_valid", 32'(op_valid), 32'(e.op_valid));
        if (e.op_valid) begin
          if (op_q.size() == 0) begin
            check("op_expect_present", 32'(op_q.size()), 32'd1);
          end else begin
            o = op_q.pop_front();
            check("operacion", 32'(operacion), 32'(o.op));
            check("illegal", 32'(illegal), 32'(o.ill));
            check("md_start", 32'(md_start), 32'(o.mds));
          end
        end else begin
          check("md_start_quiet", 32'(md_start), 32'd0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_out"}, 32'(ready_out), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_md_done"}, 32'(md_done), 32'd0);
    check({tag, "_op_valid"}, 32'(op_valid), 32'd0);
    check({tag, "_md_start"}, 32'(md_start), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
    check({tag, "_operacion"}, 32'(operacion), 32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rem = 0;
    seed();
    mon_en = 1'b1;

    // First request: R-type ADD
    step(1'b1, 3'b010, 6'h20, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);

    // Every dataUC code, then every listed Function plus an unlisted one
    for (int unsigned d = 0; d < 8; d++) step(1'b1, 3'(d), 6'h20, 1'b0);
    for (int unsigned f = 0; f < 13; f++) begin
      step(1'b1, 3'b010, fn_list[f], 1'b0);
      if (fn_list[f] == 6'h18 || fn_list[f] == 6'h1A)
        for (int unsigned k = 0; k < DIV_LAT; k++) step(1'b0, 3'b000, 6'h00, 1'b0);
    end
    step(1'b1, 3'b010, 6'h3F, 1'b0);
    step(1'b1, 3'b110, 6'h20, 1'b0);

    // MULT followed by an ADD held valid
    step(1'b1, 3'b010, 6'h18, 1'b0);
    for (int unsigned k = 0; k < 6; k++) step(1'b1, 3'b000, 6'h00, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);

    // DIV with ADD held valid throughout the busy window
    step(1'b1, 3'b010, 6'h1A, 1'b0);
    for (int unsigned k = 0; k < DIV_LAT + 1; k++) step(1'b1, 3'b000, 6'h00, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);

    // DIV aborted by flush with a competing request
    step(1'b1, 3'b010, 6'h1A, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);
    step(1'b1, 3'b001, 6'h00, 1'b1);
    step(1'b1, 3'b001, 6'h00, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b1);

    // MULT interrupted by asynchronous reset
    step(1'b1, 3'b010, 6'h18, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b0);
    @(negedge clk); #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midseq_reset");
    cyc_q.delete();
    op_q.delete();
    rem = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    seed();
    mon_en = 1'b1;
    for (int unsigned k = 0; k < MUL_LAT + 2; k++) step(1'b0, 3'b000, 6'h00, 1'b0);

    // Randomized traffic
    for (int unsigned n = 0; n < 2000; n++) begin
      logic [5:0] fn;
      if ($urandom_range(3) != 0) fn = fn_list[$urandom_range(12)];
      else fn = 6'($urandom);
      step(1'($urandom), 3'($urandom), fn, $urandom_range(19) == 0);
    end
    for (int unsigned k = 0; k < DIV_LAT + 2; k++) step(1'b0, 3'b000, 6'h00, 1'b0);

    @(negedge clk); #1;
    mon_en = 1'b0;
    check("cyc_queue_drained", 32'(cyc_q.size()), 32'd0);
    check("op_queue_drained", 32'(op_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
